// File: rtl/nibble_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module : nibble_sub_pkg
// Brief  : Shared state encoding and nibble width for the serial subtractor.
// Rev    : 1.0
// ============================================================================
package nibble_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_sub_pkg
`default_nettype wire

// File: rtl/subtractor_4_bit.sv
`default_nettype none
// ============================================================================
// Module : subtractor_4_bit
// Brief  : 4-bit ripple-borrow subtractor, z = x - y - bi, bo = borrow out.
// Rev    : 1.0
// ============================================================================
module subtractor_4_bit
  import nibble_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x_i,
  input  logic [NIBBLE_W-1:0] y_i,
  input  logic                bi_i,
  output logic [NIBBLE_W-1:0] z_o,
  output logic                bo_o
);

  logic [NIBBLE_W:0] w_b;

  assign w_b[0] = bi_i;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign z_o[i]   = x_i[i] ^ y_i[i] ^ w_b[i];
    assign w_b[i+1] = (~x_i[i] & y_i[i]) | (~(x_i[i] ^ y_i[i]) & w_b[i]);
  end

  assign bo_o = w_b[NIBBLE_W];

endmodule : subtractor_4_bit
`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : nibble_serial_subtractor
// Brief  : Multi-nibble subtractor sequencing one shared 4-bit stage LSB->MSB.
// Rev    : 1.0
// ============================================================================
module nibble_serial_subtractor
  import nibble_sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    in_x,
  input  logic [4*NIBBLES-1:0]    in_y,
  input  logic                    in_bi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    out_diff,
  output logic                    out_bo,
  output logic                    out_zero,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       x_q, x_d;
  logic [W-1:0]       y_q, y_d;
  logic [W-1:0]       diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NIBBLE_W-1:0] w_x_nib;
  logic [NIBBLE_W-1:0] w_y_nib;
  logic [NIBBLE_W-1:0] w_z_nib;
  logic                w_bo;

  assign w_x_nib = x_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign w_y_nib = y_q[NIBBLE_W*idx_q +: NIBBLE_W];

  subtractor_4_bit u_sub (
    .x_i  (w_x_nib),
    .y_i  (w_y_nib),
    .bi_i (borrow_q),
    .z_o  (w_z_nib),
    .bo_o (w_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d      = in_x;
          y_d      = in_y;
          borrow_d = in_bi;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[NIBBLE_W*idx_q +: NIBBLE_W] = w_z_nib;
        borrow_d = w_bo;
        // idx wraps to 0 on the last nibble so it never exceeds NIBBLES-1.
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_diff  = diff_q;
  assign out_bo    = borrow_q;
  assign out_zero  = (diff_q == '0);

endmodule : nibble_serial_subtractor
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : tb_nibble_serial_subtractor
// Brief  : Directed self-checking bench for NIBBLES=4 and NIBBLES=1 instances.
// Rev    : 1.0
// ============================================================================
module tb_nibble_serial_subtractor;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, in_bi;
  logic [15:0] in_x, in_y;
  logic        in_ready, out_valid, out_bo, out_zero, busy;
  logic [15:0] out_diff;

  logic        in_valid1, out_ready1, in_bi1;
  logic [3:0]  in_x1, in_y1;
  logic        in_ready1, out_valid1, out_bo1, out_zero1, busy1;
  logic [3:0]  out_diff1;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_bi(in_bi),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_bo(out_bo), .out_zero(out_zero), .busy(busy)
  );

  nibble_serial_subtractor #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_x(in_x1), .in_y(in_y1), .in_bi(in_bi1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_diff(out_diff1), .out_bo(out_bo1), .out_zero(out_zero1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept at the next edge, expect out_valid exactly 4 edges later, then drain.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic bi, input logic [15:0] ed, input logic eb,
                        input logic ez);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_x = x; in_y = y; in_bi = bi; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_diff"}, 32'(out_diff), 32'(ed));
    chk({tag, "_bo"}, 32'(out_bo), 32'(eb));
    chk({tag, "_zero"}, 32'(out_zero), 32'(ez));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_diff"}, 32'(out_diff), 32'd0);
    chk({tag, "_bo"}, 32'(out_bo), 32'd0);
    chk({tag, "_zero"}, 32'(out_zero), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_bi = 1'b0; in_x = '0; in_y = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_bi1 = 1'b0; in_x1 = '0; in_y1 = '0;
    step();
    chk_reset_vals("reset");
    step();
    rst_n = 1'b1;
    step();
    chk_reset_vals("post_reset");

    run_op("t1", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    run_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("t3", 16'h5A5A, 16'h5A59, 1'b1, 16'h0000, 1'b0, 1'b1);

    // Hold the result with out_ready low while new operands are offered.
    in_x = 16'h8000; in_y = 16'h0001; in_bi = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("t4_valid", 32'(out_valid), 32'd1);
    in_x = 16'hAAAA; in_y = 16'h1111; in_bi = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      in_valid = (i % 2 == 0);
      chk("t4_hold_diff", 32'(out_diff), 32'h7FFF);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
    end
    chk("t4_hold_bo", 32'(out_bo), 32'd0);
    in_x = 16'h0F0F; in_y = 16'h0101; in_bi = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_idle_valid", 32'(out_valid), 32'd0);
    chk("t4_idle_ready", 32'(in_ready), 32'd1);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    chk("t4_accept_busy", 32'(busy), 32'd1);
    repeat (3) step();
    chk("t4_next_early", 32'(out_valid), 32'd0);
    step();
    chk("t4_next_valid", 32'(out_valid), 32'd1);
    chk("t4_next_diff", 32'(out_diff), 32'h0E0E);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset two cycles into RUN aborts the operation.
    in_x = 16'h1111; in_y = 16'h0001; in_bi = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5_abort");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_idle_after", 32'(out_valid), 32'd0);
    end
    run_op("t5", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

    // Single-nibble instance: RUN is one cycle.
    chk("t6_ready", 32'(in_ready1), 32'd1);
    in_x1 = 4'h3; in_y1 = 4'h5; in_bi1 = 1'b0; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("t6_run_valid", 32'(out_valid1), 32'd0);
    step();
    chk("t6_valid", 32'(out_valid1), 32'd1);
    chk("t6_diff", 32'(out_diff1), 32'hE);
    chk("t6_bo", 32'(out_bo1), 32'd1);
    chk("t6_zero", 32'(out_zero1), 32'd0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("t6_drained", 32'(out_valid1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nibble_serial_subtractor
`default_nettype wire
